// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - Pacoblaze port-bus initiator: buffered host read/write commands to io peripherals
// Reads stall behind an unread response; the interrupt re-arms only after the request line is seen low.
module io_bus_master #(
  parameter int CMD_DEPTH = 4,
  parameter int READ_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       int_pending,
  input  logic       int_clear,
  output logic       busy,
  output logic [7:0] port_id,
  output logic [7:0] port_in,
  input  logic [7:0] port_out,
  output logic       wen,
  output logic       ren,
  input  logic       interrupt,
  output logic       interrupt_ack
);

  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [3:0] WAIT_LAST = 4'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_STB,
    RD_WAIT,
    RD_CAP,
    ACK
  } state_t;

  state_t state, state_nx;

  // Each entry is {write, addr, data}; pointers carry one extra bit to tell full from empty.
  logic [16:0] fifo_mem [CMD_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic [16:0] head;
  logic        head_write;
  logic [7:0]  head_addr, head_data;
  logic [3:0]  wait_cnt;
  logic        armed;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;

  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign head_write = head[16];
  assign head_addr  = head[15:8];
  assign head_data  = head[7:0];

  assign busy = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {cmd_write, cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    wen           = 1'b0;
    ren           = 1'b0;
    interrupt_ack = 1'b0;
    case (state)
      IDLE: begin
        if (int_pending && int_clear) begin
          state_nx = ACK;
        end else if (!fifo_empty && head_write) begin
          pop      = 1'b1;
          state_nx = WR;
        end else if (!fifo_empty && !rsp_valid) begin
          pop      = 1'b1;
          state_nx = RD_STB;
        end
      end
      WR: begin
        wen      = 1'b1;
        state_nx = IDLE;
      end
      RD_STB: begin
        ren      = 1'b1;
        state_nx = (READ_WAIT > 0) ? RD_WAIT : RD_CAP;
      end
      RD_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nx = RD_CAP;
        end
      end
      RD_CAP: begin
        state_nx = IDLE;
      end
      ACK: begin
        interrupt_ack = 1'b1;
        state_nx      = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != RD_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Bus address/data are loaded on the pop so they are valid during the strobe cycle and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_id <= '0;
      port_in <= '0;
    end else if (pop) begin
      port_id <= head_addr;
      if (head_write) begin
        port_in <= head_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (state == RD_CAP) begin
      rsp_valid <= 1'b1;
      rsp_data  <= port_out;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // ACK beats a same-cycle capture; the level must drop before another capture can happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_pending <= 1'b0;
      armed       <= 1'b1;
    end else if (state == ACK) begin
      int_pending <= 1'b0;
      armed       <= 1'b0;
    end else if (!interrupt) begin
      armed <= 1'b1;
    end else if (armed) begin
      int_pending <= 1'b1;
    end
  end

endmodule
